// File: rtl/axis_rr_arbiter.sv
// Round-robin, packet-locking AXI4-Stream arbiter: registered one-hot grant one cycle after request.
// Grant is held until the granted packet's tlast beat is accepted; one idle bubble between packets.
module axis_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 xfer,
  input  logic                 xfer_last,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 grant_valid
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     last_idx, last_idx_nxt;
  logic [NUM_PORTS-1:0] grant_nxt;
  logic                 grant_valid_nxt;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand;

  // Search starts one past the previous winner and wraps, so the previous
  // winner is considered last and can only win again if it is alone.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_idx;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((int'(last_idx) + k) % NUM_PORTS);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    last_idx_nxt    = last_idx;
    grant_nxt       = grant;
    grant_valid_nxt = grant_valid;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt          = LOCKED;
          last_idx_nxt       = win_idx;
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          grant_valid_nxt    = 1'b1;
        end
      end
      LOCKED: begin
        // Only an accepted tlast beat releases the lock; req is not looked at.
        if (xfer && xfer_last) begin
          state_nxt       = IDLE;
          grant_nxt       = '0;
          grant_valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt       = IDLE;
        grant_nxt       = '0;
        grant_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      last_idx    <= IDX_W'(NUM_PORTS - 1);
      grant       <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_idx    <= last_idx_nxt;
      grant       <= grant_nxt;
      grant_valid <= grant_valid_nxt;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter (NUM_PORTS=4); expected grants are hand-computed per step.
module tb_axis_rr_arbiter;

  logic       aclk;
  logic       aresetn;
  logic [3:0] req;
  logic       xfer;
  logic       xfer_last;
  logic [3:0] grant;
  logic       grant_valid;

  int checks = 0;
  int errors = 0;

  axis_rr_arbiter #(.NUM_PORTS(4)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req         (req),
    .xfer        (xfer),
    .xfer_last   (xfer_last),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] exp);
    chk({tag, ".grant"}, 32'(grant), 32'(exp));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(|exp));
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  logic [3:0] rot_exp [8];

  initial begin
    rot_exp = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    aresetn   = 1'b0;
    req       = 4'b1111;
    xfer      = 1'b0;
    xfer_last = 1'b0;

    // Reset held with all ports requesting
    #2;
    expect_grant("rst0", 4'b0000);
    step();
    expect_grant("rst1", 4'b0000);
    step();
    expect_grant("rst2", 4'b0000);
    aresetn = 1'b1;
    step();
    expect_grant("rst_rel", 4'b0001);

    // Rotation with single-beat packets
    xfer      = 1'b1;
    xfer_last = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_grant($sformatf("rot%0d", i), rot_exp[i]);
    end

    // Release port 0, then grant port 2
    step();
    expect_grant("rel0", 4'b0000);
    xfer      = 1'b0;
    xfer_last = 1'b0;
    req       = 4'b0100;
    step();
    expect_grant("p2", 4'b0100);

    // Packet lock: 3 beats, tlast on the third, req changing underneath
    xfer = 1'b1;
    req  = 4'b0011;
    expect_grant("lock_b1", 4'b0100);
    step();
    req = 4'b0000;
    expect_grant("lock_b2", 4'b0100);
    step();
    req       = 4'b0011;
    xfer_last = 1'b1;
    expect_grant("lock_b3", 4'b0100);
    step();
    expect_grant("lock_rel", 4'b0000);
    xfer      = 1'b0;
    xfer_last = 1'b0;
    step();
    expect_grant("lock_next", 4'b0001);

    // Sparse / wrap: get port 3 to win, then req=1010 must wrap to port 1
    xfer      = 1'b1;
    xfer_last = 1'b1;
    req       = 4'b1000;
    step();
    expect_grant("w_rel0", 4'b0000);
    xfer = 1'b0;
    step();
    expect_grant("w_p3", 4'b1000);
    xfer = 1'b1;
    req  = 4'b1010;
    step();
    expect_grant("w_rel3", 4'b0000);
    xfer = 1'b0;
    step();
    expect_grant("w_wrap", 4'b0010);
    xfer = 1'b1;
    req  = 4'b0010;
    step();
    expect_grant("w_rel1", 4'b0000);
    xfer = 1'b0;
    step();
    expect_grant("w_regrant", 4'b0010);

    // Ignored inputs in IDLE
    xfer      = 1'b1;
    xfer_last = 1'b1;
    req       = 4'b0000;
    step();
    expect_grant("ig_rel", 4'b0000);
    step();
    expect_grant("ig_both", 4'b0000);
    xfer_last = 1'b0;
    step();
    expect_grant("ig_xfer", 4'b0000);
    xfer      = 1'b0;
    xfer_last = 1'b1;
    step();
    expect_grant("ig_last", 4'b0000);

    // Locked: xfer_last without xfer holds the grant
    xfer_last = 1'b0;
    req       = 4'b0001;
    step();
    expect_grant("hl_p0", 4'b0001);
    req       = 4'b0000;
    xfer_last = 1'b1;
    step();
    expect_grant("hl_hold1", 4'b0001);
    step();
    expect_grant("hl_hold2", 4'b0001);
    xfer = 1'b1;
    step();
    expect_grant("hl_rel", 4'b0000);

    // Reset mid-packet while port 2 is granted
    xfer      = 1'b0;
    xfer_last = 1'b0;
    req       = 4'b0100;
    step();
    expect_grant("mr_p2", 4'b0100);
    #3;
    aresetn = 1'b0;
    #1;
    expect_grant("mr_async", 4'b0000);
    step();
    expect_grant("mr_held", 4'b0000);
    #2;
    aresetn = 1'b1;
    step();
    expect_grant("mr_p2b", 4'b0100);
    xfer      = 1'b1;
    xfer_last = 1'b1;
    req       = 4'b0101;
    step();
    expect_grant("mr_rel", 4'b0000);
    xfer      = 1'b0;
    xfer_last = 1'b0;
    step();
    expect_grant("mr_p0", 4'b0001);

    // History lost: previously port 2 won, yet after reset req=1100 must pick port 2, not 3
    xfer      = 1'b1;
    xfer_last = 1'b1;
    req       = 4'b0100;
    step();
    xfer      = 1'b0;
    xfer_last = 1'b0;
    step();
    expect_grant("hist_p2", 4'b0100);
    #3;
    aresetn = 1'b0;
    req     = 4'b1100;
    #3;
    aresetn = 1'b1;
    step();
    expect_grant("hist_fresh", 4'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
